lenet_stage_sequencer: RTL

- Top-level sequencer for the chained LeNet layer pipeline (conv/maxpool/fc stages linked by enable / finished_for_next_device / reply handshakes).
- Admits input frames from the host into the first stage and accepts results from the last stage on behalf of the host sink.
- Tracks frames in flight, throttles admission and counts completed frames.
- Runs a watchdog that halts the pipeline if it stops making progress.

---
 rtl/lenet_stage_sequencer.sv | 113 +++++++++++
 1 files changed

// File: rtl/lenet_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lenet_stage_sequencer
// Purpose  : Admits host frames into the LeNet stage chain, accepts results
//            from the last stage, throttles in-flight frames, runs a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module lenet_stage_sequencer #(
   parameter int MAX_INFLIGHT = 4,
   parameter int TIMEOUT      = 4096,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_valid,
   output logic             frame_ready,
   output logic             stage_enable,
   input  logic             stage0_reply,
   input  logic             last_finished,
   output logic             last_reply,
   output logic             result_valid,
   input  logic             result_ready,
   input  logic             clear_error,
   output logic             busy,
   output logic [3:0]       inflight,
   output logic [CNT_W-1:0] frame_count,
   output logic             error_timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      ERROR  = 2'd2
   } state_t;

   localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [4:0]      MAX_N   = 5'(MAX_INFLIGHT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   state_t          state;
   logic [WD_W-1:0] watchdog;
   logic            admit;
   logic            accept;
   logic            sink_stall;
   logic            wd_clear;
   logic            wd_expire;
   logic [4:0]      inflight_ext;

   assign inflight_ext = {1'b0, inflight};

   assign result_valid = last_finished && (state != ERROR);
   assign last_reply   = result_valid && result_ready;
   assign accept       = last_reply;
   assign admit        = (state == LAUNCH) && stage0_reply;
   assign frame_ready  = admit;
   assign busy         = (inflight != 4'd0) || (state != IDLE);

   // A sink holding off a valid result is not a pipeline stall.
   assign sink_stall = result_valid && !result_ready;
   assign wd_clear   = admit || accept || ((inflight == 4'd0) && (state != LAUNCH));
   // Expiry implies no admit/accept this cycle, so nothing is lost on entry.
   assign wd_expire  = (state != ERROR) && !wd_clear && !sink_stall && (watchdog == WD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         stage_enable  <= 1'b0;
         error_timeout <= 1'b0;
         inflight      <= 4'd0;
         frame_count   <= '0;
         watchdog      <= '0;
      end else if (state == ERROR) begin
         if (clear_error) begin
            state         <= IDLE;
            error_timeout <= 1'b0;
            inflight      <= 4'd0;
            watchdog      <= '0;
         end
      end else if (wd_expire) begin
         state         <= ERROR;
         stage_enable  <= 1'b0;
         error_timeout <= 1'b1;
      end else begin
         if (wd_clear)
            watchdog <= '0;
         else if (!sink_stall)
            watchdog <= watchdog + WD_W'(1);

         if (accept)
            frame_count <= frame_count + CNT_W'(1);

         if (admit && !accept)
            inflight <= inflight + 4'd1;
         else if (accept && !admit && (inflight != 4'd0))
            inflight <= inflight - 4'd1;

         if (state == IDLE) begin
            if (frame_valid && (inflight_ext < MAX_N)) begin
               state        <= LAUNCH;
               stage_enable <= 1'b1;
            end
         end else if (stage0_reply) begin
            // Stay launching only if another frame waits and room remains after this one.
            if (!(frame_valid && ((inflight_ext + 5'd1) < MAX_N))) begin
               state        <= IDLE;
               stage_enable <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire
